// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: bus geometry,
// FSM state encoding and the address error decode.
package mips_mem_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int BYTE_LANES = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Misaligned byte address, or any bit set above the implemented word range.
    function automatic logic addr_error(input logic [BUS_WIDTH-1:0] addr,
                                        input int                   addr_width);
        logic hi_bits;
        hi_bits = 1'b0;
        for (int i = 2; i < BUS_WIDTH; i++) begin
            if (i >= addr_width + 2 && addr[i]) begin
                hi_bits = 1'b1;
            end
        end
        return (addr[1:0] != 2'b00) || hi_bits;
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store request/acknowledge bus between the MIPS core (master) and
// its data memory (slave).
interface mips_dmem_responder_if;
    import mips_mem_pkg::*;

    logic                  req;
    logic                  we;
    logic [BUS_WIDTH-1:0]  addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [BYTE_LANES-1:0] be;
    logic [BUS_WIDTH-1:0]  rdata;
    logic                  ack;
    logic                  err;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err
    );

endinterface

// File: rtl/mips_bytewrite_ram.sv
// Single-port 2**ADDR_WIDTH x 32 RAM with per-byte write enables and a
// registered read port; one byte-wide array per lane so each maps to block RAM.
module mips_bytewrite_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [BYTE_LANES-1:0] we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0]  wdata,
    output logic [BUS_WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
            logic [7:0] q_reg;

            if (INIT_ZERO != 0) begin : g_init
                logic [7:0] lane_mem [DEPTH] = '{default: 8'h00};

                always_ff @(posedge clk) begin
                    if (en) begin
                        if (we[gi]) begin
                            lane_mem[addr] <= wdata[gi*8 +: 8];
                        end
                        q_reg <= lane_mem[addr];
                    end
                end
            end else begin : g_noinit
                logic [7:0] lane_mem [DEPTH];

                always_ff @(posedge clk) begin
                    if (en) begin
                        if (we[gi]) begin
                            lane_mem[addr] <= wdata[gi*8 +: 8];
                        end
                        q_reg <= lane_mem[addr];
                    end
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-side memory target for the MIPS core: accepts one request at a time,
// inserts WAIT_CYCLES wait states, then acks with read data or an error.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_dmem_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_t           state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  we_reg;
    logic [BUS_WIDTH-1:0]  addr_reg;
    logic [BUS_WIDTH-1:0]  wdata_reg;
    logic [BYTE_LANES-1:0] be_reg;
    logic                  err_reg;

    logic                  launch;
    logic                  use_live;
    logic                  op_we;
    logic                  op_err;
    logic [BUS_WIDTH-1:0]  op_addr;
    logic [BUS_WIDTH-1:0]  op_wdata;
    logic [BYTE_LANES-1:0] op_be;
    logic                  ram_en;
    logic [BYTE_LANES-1:0] ram_we;
    logic [BUS_WIDTH-1:0]  ram_q;

    // launch marks the edge entering RESP: the RAM read and any store commit
    // happen there so the registered read data is valid during RESP.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        launch     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        launch     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = RESP;
                    cnt_next   = 4'd0;
                    launch     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // With zero wait states the RAM is driven on the acceptance edge itself,
    // before the capture registers hold the request.
    assign use_live = (state_reg == IDLE);
    assign op_we    = use_live ? bus.we    : we_reg;
    assign op_addr  = use_live ? bus.addr  : addr_reg;
    assign op_wdata = use_live ? bus.wdata : wdata_reg;
    assign op_be    = use_live ? bus.be    : be_reg;
    assign op_err   = use_live ? addr_error(bus.addr, ADDR_WIDTH) : err_reg;

    assign ram_en = launch && !rst;
    assign ram_we = (op_we && !op_err) ? op_be : '0;

    mips_bytewrite_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_ZERO  (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (op_addr[ADDR_WIDTH+1:2]),
        .wdata (op_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && bus.req) begin
                we_reg    <= bus.we;
                err_reg   <= addr_error(bus.addr, ADDR_WIDTH);
                addr_reg  <= bus.addr;
                wdata_reg <= bus.wdata;
                be_reg    <= bus.be;
            end
        end
    end

    assign bus.ack   = (state_reg == RESP);
    assign bus.err   = (state_reg == RESP) && err_reg;
    assign bus.rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? ram_q : '0;

endmodule
